mips_decode_exec: RTL and testbench

- Single-cycle MIPS decode/execute slice: instruction register, field decoder, main/ALU control unit, immediate extender, ALU operand mux and 32-bit ALU.
- Sits between memory data bus and the register file / PC / memory-address mux of the CPU top.
- Register file and PC are external.

---
 rtl/mips_decode_exec.sv | 199 +++++++++++++++++++
 tb/tb_mips_decode_exec.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_decode_exec.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mips_decode_exec: single-cycle MIPS IR, decoder, control unit and ALU  |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
module mips_decode_exec #(
  parameter int DATA_W = 32
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              inst_load,
  input  logic [31:0]       inst_in,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [31:0]       inst,
  output logic [5:0]        decode_opcode,
  output logic [4:0]        decode_rs,
  output logic [4:0]        decode_rt,
  output logic [4:0]        decode_rd,
  output logic [4:0]        decode_shamt,
  output logic [5:0]        decode_funct,
  output logic [15:0]       decode_imm16,
  output logic [25:0]       decode_jmp_target,
  output logic [DATA_W-1:0] imm_ext,
  output logic              cpu_ctrl_reg_dst,
  output logic              cpu_ctrl_reg_write,
  output logic              cpu_ctrl_mem_to_reg,
  output logic              cpu_ctrl_mem_read,
  output logic              cpu_ctrl_mem_write,
  output logic              cpu_ctrl_mem_addr_src,
  output logic              cpu_ctrl_alu_src,
  output logic              cpu_ctrl_sign_expand,
  output logic              cpu_ctrl_branch,
  output logic              cpu_ctrl_jmp,
  output logic              cpu_ctrl_syscall,
  output logic [3:0]        cpu_ctrl_alu_ctrl,
  output logic [DATA_W-1:0] alu_out,
  output logic              alu_zero,
  output logic              alu_overflow,
  output logic              alu_carry
);

  localparam logic [3:0] c_alu_and = 4'h0;
  localparam logic [3:0] c_alu_or  = 4'h1;
  localparam logic [3:0] c_alu_add = 4'h2;
  localparam logic [3:0] c_alu_sub = 4'h6;
  localparam logic [3:0] c_alu_slt = 4'h7;

  localparam logic [5:0] c_op_rtype = 6'd0;
  localparam logic [5:0] c_op_j     = 6'd2;
  localparam logic [5:0] c_op_beq   = 6'd4;
  localparam logic [5:0] c_op_addi  = 6'd8;
  localparam logic [5:0] c_op_slti  = 6'd10;
  localparam logic [5:0] c_op_andi  = 6'd12;
  localparam logic [5:0] c_op_ori   = 6'd13;
  localparam logic [5:0] c_op_lw    = 6'd35;
  localparam logic [5:0] c_op_sw    = 6'd43;

  localparam logic [5:0] c_fn_syscall = 6'h0C;
  localparam logic [5:0] c_fn_add     = 6'h20;
  localparam logic [5:0] c_fn_sub     = 6'h22;
  localparam logic [5:0] c_fn_and     = 6'h24;
  localparam logic [5:0] c_fn_or      = 6'h25;
  localparam logic [5:0] c_fn_slt     = 6'h2A;

  logic [31:0] r_ir;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_ir <= '0;
    end else if (inst_load) begin
      r_ir <= inst_in;
    end
  end

  assign inst              = r_ir;
  assign decode_opcode     = r_ir[31:26];
  assign decode_rs         = r_ir[25:21];
  assign decode_rt         = r_ir[20:16];
  assign decode_rd         = r_ir[15:11];
  assign decode_shamt      = r_ir[10:6];
  assign decode_funct      = r_ir[5:0];
  assign decode_imm16      = r_ir[15:0];
  assign decode_jmp_target = r_ir[25:0];

  // Unsupported opcodes/functs fall through the defaults and behave as a NOP.
  always_comb begin
    cpu_ctrl_reg_dst      = 1'b0;
    cpu_ctrl_reg_write    = 1'b0;
    cpu_ctrl_mem_to_reg   = 1'b0;
    cpu_ctrl_mem_read     = 1'b0;
    cpu_ctrl_mem_write    = 1'b0;
    cpu_ctrl_mem_addr_src = 1'b0;
    cpu_ctrl_alu_src      = 1'b0;
    cpu_ctrl_sign_expand  = 1'b0;
    cpu_ctrl_branch       = 1'b0;
    cpu_ctrl_jmp          = 1'b0;
    cpu_ctrl_syscall      = 1'b0;
    cpu_ctrl_alu_ctrl     = c_alu_add;
    case (decode_opcode)
      c_op_rtype: begin
        case (decode_funct)
          c_fn_add, c_fn_sub, c_fn_and, c_fn_or, c_fn_slt: begin
            cpu_ctrl_reg_dst   = 1'b1;
            cpu_ctrl_reg_write = 1'b1;
            case (decode_funct)
              c_fn_sub: cpu_ctrl_alu_ctrl = c_alu_sub;
              c_fn_and: cpu_ctrl_alu_ctrl = c_alu_and;
              c_fn_or:  cpu_ctrl_alu_ctrl = c_alu_or;
              c_fn_slt: cpu_ctrl_alu_ctrl = c_alu_slt;
              default:  cpu_ctrl_alu_ctrl = c_alu_add;
            endcase
          end
          c_fn_syscall: cpu_ctrl_syscall = 1'b1;
          default: ;
        endcase
      end
      c_op_lw: begin
        cpu_ctrl_alu_src      = 1'b1;
        cpu_ctrl_sign_expand  = 1'b1;
        cpu_ctrl_mem_read     = 1'b1;
        cpu_ctrl_mem_to_reg   = 1'b1;
        cpu_ctrl_reg_write    = 1'b1;
        cpu_ctrl_mem_addr_src = 1'b1;
      end
      c_op_sw: begin
        cpu_ctrl_alu_src      = 1'b1;
        cpu_ctrl_sign_expand  = 1'b1;
        cpu_ctrl_mem_write    = 1'b1;
        cpu_ctrl_mem_addr_src = 1'b1;
      end
      c_op_beq: begin
        cpu_ctrl_branch      = 1'b1;
        cpu_ctrl_sign_expand = 1'b1;
        cpu_ctrl_alu_ctrl    = c_alu_sub;
      end
      c_op_j: cpu_ctrl_jmp = 1'b1;
      c_op_addi, c_op_slti: begin
        cpu_ctrl_alu_src     = 1'b1;
        cpu_ctrl_sign_expand = 1'b1;
        cpu_ctrl_reg_write   = 1'b1;
        cpu_ctrl_alu_ctrl    = (decode_opcode == c_op_slti) ? c_alu_slt : c_alu_add;
      end
      c_op_andi, c_op_ori: begin
        cpu_ctrl_alu_src   = 1'b1;
        cpu_ctrl_reg_write = 1'b1;
        cpu_ctrl_alu_ctrl  = (decode_opcode == c_op_ori) ? c_alu_or : c_alu_and;
      end
      default: ;
    endcase
  end

  assign imm_ext = cpu_ctrl_sign_expand ? {{(DATA_W-16){decode_imm16[15]}}, decode_imm16}
                                        : {{(DATA_W-16){1'b0}}, decode_imm16};

  logic [DATA_W-1:0] w_in1;
  logic [DATA_W-1:0] w_in2;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic              w_add_ov;
  logic              w_sub_ov;
  logic              w_lt;

  assign w_in1 = rs_data;
  assign w_in2 = cpu_ctrl_alu_src ? imm_ext : rt_data;

  assign w_sum    = {1'b0, w_in1} + {1'b0, w_in2};
  assign w_diff   = {1'b0, w_in1} + {1'b0, ~w_in2} + (DATA_W+1)'(1);
  assign w_add_ov = (w_in1[DATA_W-1] == w_in2[DATA_W-1]) && (w_sum[DATA_W-1] != w_in1[DATA_W-1]);
  assign w_sub_ov = (w_in1[DATA_W-1] != w_in2[DATA_W-1]) && (w_diff[DATA_W-1] != w_in1[DATA_W-1]);
  // The difference's sign is inverted exactly when the subtraction overflows.
  assign w_lt     = w_diff[DATA_W-1] ^ w_sub_ov;

  always_comb begin
    alu_out      = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (cpu_ctrl_alu_ctrl)
      c_alu_add: begin
        alu_out      = w_sum[DATA_W-1:0];
        alu_carry    = w_sum[DATA_W];
        alu_overflow = w_add_ov;
      end
      c_alu_sub: begin
        alu_out      = w_diff[DATA_W-1:0];
        alu_carry    = w_diff[DATA_W];
        alu_overflow = w_sub_ov;
      end
      c_alu_and: alu_out = w_in1 & w_in2;
      c_alu_or:  alu_out = w_in1 | w_in2;
      c_alu_slt: alu_out = {{(DATA_W-1){1'b0}}, w_lt};
      default: ;
    endcase
  end

  assign alu_zero = (alu_out == '0);

endmodule
`default_nettype wire

// File: tb/tb_mips_decode_exec.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mips_decode_exec: scoreboard bench for the decode/execute slice     |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_mips_decode_exec;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b1;
  logic        inst_load = 1'b0;
  logic [31:0] inst_in = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic [31:0] inst;
  logic [5:0]  decode_opcode;
  logic [4:0]  decode_rs, decode_rt, decode_rd, decode_shamt;
  logic [5:0]  decode_funct;
  logic [15:0] decode_imm16;
  logic [25:0] decode_jmp_target;
  logic [31:0] imm_ext;
  logic        reg_dst, reg_write, mem_to_reg, mem_read, mem_write, mem_addr_src;
  logic        alu_src, sign_expand, branch, jmp, syscall;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_out;
  logic        alu_zero, alu_overflow, alu_carry;

  int n_tests = 0;
  int n_fail  = 0;

  mips_decode_exec #(.DATA_W(32)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .inst_load(inst_load), .inst_in(inst_in),
    .rs_data(rs_data), .rt_data(rt_data), .inst(inst),
    .decode_opcode(decode_opcode), .decode_rs(decode_rs), .decode_rt(decode_rt),
    .decode_rd(decode_rd), .decode_shamt(decode_shamt), .decode_funct(decode_funct),
    .decode_imm16(decode_imm16), .decode_jmp_target(decode_jmp_target), .imm_ext(imm_ext),
    .cpu_ctrl_reg_dst(reg_dst), .cpu_ctrl_reg_write(reg_write),
    .cpu_ctrl_mem_to_reg(mem_to_reg), .cpu_ctrl_mem_read(mem_read),
    .cpu_ctrl_mem_write(mem_write), .cpu_ctrl_mem_addr_src(mem_addr_src),
    .cpu_ctrl_alu_src(alu_src), .cpu_ctrl_sign_expand(sign_expand),
    .cpu_ctrl_branch(branch), .cpu_ctrl_jmp(jmp), .cpu_ctrl_syscall(syscall),
    .cpu_ctrl_alu_ctrl(alu_ctrl), .alu_out(alu_out), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry(alu_carry)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Bit order: reg_dst, reg_write, mem_to_reg, mem_read, mem_write,
  // mem_addr_src, alu_src, sign_expand, branch, jmp, syscall.
  logic [10:0] ctrl_bus;
  assign ctrl_bus = {reg_dst, reg_write, mem_to_reg, mem_read, mem_write, mem_addr_src,
                     alu_src, sign_expand, branch, jmp, syscall};

  typedef struct {
    logic [31:0] inst;
    logic [10:0] ctrl;
    logic [3:0]  aluc;
    logic [31:0] imm;
    logic [31:0] out;
    logic [2:0]  flags;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] cur_ir = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] in2;
    longint      sa, sb2, sr;
    logic        ov, cy;
    e.inst = ir;
    e.ctrl = 11'b0;
    e.aluc = 4'h2;
    case (ir[31:26])
      6'd0: case (ir[5:0])
        6'h20: begin e.ctrl = 11'b11000000000; e.aluc = 4'h2; end
        6'h22: begin e.ctrl = 11'b11000000000; e.aluc = 4'h6; end
        6'h24: begin e.ctrl = 11'b11000000000; e.aluc = 4'h0; end
        6'h25: begin e.ctrl = 11'b11000000000; e.aluc = 4'h1; end
        6'h2A: begin e.ctrl = 11'b11000000000; e.aluc = 4'h7; end
        6'h0C: e.ctrl = 11'b00000000001;
        default: ;
      endcase
      6'd35: e.ctrl = 11'b01110111000;
      6'd43: e.ctrl = 11'b00001111000;
      6'd4:  begin e.ctrl = 11'b00000001100; e.aluc = 4'h6; end
      6'd2:  e.ctrl = 11'b00000000010;
      6'd8:  e.ctrl = 11'b01000011000;
      6'd10: begin e.ctrl = 11'b01000011000; e.aluc = 4'h7; end
      6'd12: begin e.ctrl = 11'b01000010000; e.aluc = 4'h0; end
      6'd13: begin e.ctrl = 11'b01000010000; e.aluc = 4'h1; end
      default: ;
    endcase
    e.imm = e.ctrl[3] ? {{16{ir[15]}}, ir[15:0]} : {16'h0, ir[15:0]};
    in2 = e.ctrl[4] ? e.imm : b;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(in2));
    ov  = 1'b0;
    cy  = 1'b0;
    e.out = '0;
    case (e.aluc)
      4'h2: begin
        sr = sa + sb2;
        e.out = a + in2;
        cy = (64'(a) + 64'(in2)) > 64'hFFFF_FFFF;
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'h6: begin
        sr = sa - sb2;
        e.out = a - in2;
        cy = (a >= in2);
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'h0: e.out = a & in2;
      4'h1: e.out = a | in2;
      4'h7: e.out = (sa < sb2) ? 32'd1 : 32'd0;
      default: ;
    endcase
    e.flags = {(e.out == 32'd0), ov, cy};
    return e;
  endfunction

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_inst"}, inst, e.inst);
      check({tag, "_ctrl"}, 32'(ctrl_bus), 32'(e.ctrl));
      check({tag, "_aluc"}, 32'(alu_ctrl), 32'(e.aluc));
      check({tag, "_imm"}, imm_ext, e.imm);
      check({tag, "_out"}, alu_out, e.out);
      check({tag, "_flags"}, 32'({alu_zero, alu_overflow, alu_carry}), 32'(e.flags));
    end
  endtask

  task automatic load(input string tag, input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b);
    @(negedge cpu_clk);
    inst_in   = ir;
    inst_load = 1'b1;
    rs_data   = a;
    rt_data   = b;
    cur_ir    = ir;
    sb.push_back(model(ir, a, b));
    @(posedge cpu_clk);
    #1;
    inst_load = 1'b0;
    compare_out(tag);
  endtask

  task automatic set_ops(input string tag, input logic [31:0] a, input logic [31:0] b);
    rs_data = a;
    rt_data = b;
    sb.push_back(model(cur_ir, a, b));
    #1;
    compare_out(tag);
  endtask

  logic [5:0]  ops[11] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8, 6'd10, 6'd12, 6'd13, 6'd15, 6'd63};
  logic [5:0]  fns[9]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h0C, 6'h00, 6'h21, 6'h27};
  logic [31:0] vals[6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_8000};

  function automatic logic [31:0] pick_val();
    if ($urandom_range(0, 1) == 0) return vals[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    logic [31:0] ir;
    rs_data = 32'h0000_0011;
    rt_data = 32'h0000_0022;
    #2;
    sb.push_back(model(32'h0, rs_data, rt_data));
    compare_out("reset");
    check("reset_aluout", alu_out, 32'h0000_0033);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;

    // Asynchronous reset between clock edges clears a loaded lw.
    load("lw_pre", 32'h8C22_0004, 32'h100, 32'h0);
    #2;
    cpu_rst = 1'b1;
    cur_ir  = '0;
    sb.push_back(model(32'h0, rs_data, rt_data));
    #1;
    compare_out("async_rst");
    check("async_rst_aluc", 32'(alu_ctrl), 32'h2);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;

    load("add", 32'h0022_1820, 32'h7FFF_FFFF, 32'h1);
    check("add_out", alu_out, 32'h8000_0000);
    check("add_ov", 32'(alu_overflow), 32'd1);
    check("add_cy", 32'(alu_carry), 32'd0);
    check("add_rd", 32'(decode_rd), 32'd3);
    check("add_regdst", 32'(reg_dst), 32'd1);

    load("lw", 32'h8C22_FFFC, 32'h100, 32'h0);
    check("lw_imm", imm_ext, 32'hFFFF_FFFC);
    check("lw_out", alu_out, 32'h0000_00FC);
    check("lw_mr", 32'({mem_read, mem_to_reg, mem_addr_src, reg_dst}), 32'b1110);

    load("ori", 32'h3422_8000, 32'h1, 32'h0);
    check("ori_imm", imm_ext, 32'h0000_8000);
    check("ori_out", alu_out, 32'h0000_8001);
    check("ori_se", 32'(sign_expand), 32'd0);

    load("beq_eq", 32'h1022_0003, 32'h5, 32'h5);
    check("beq_br", 32'(branch), 32'd1);
    check("beq_aluc", 32'(alu_ctrl), 32'h6);
    check("beq_zero", 32'(alu_zero), 32'd1);
    set_ops("beq_ne", 32'h5, 32'h6);
    check("beq_ne_zero", 32'(alu_zero), 32'd0);
    check("beq_ne_cy", 32'(alu_carry), 32'd0);

    load("slt", 32'h0022_182A, 32'h8000_0000, 32'h1);
    check("slt_out", alu_out, 32'h1);
    set_ops("slt_rev", 32'h1, 32'h8000_0000);
    check("slt_rev_out", alu_out, 32'h0);

    load("syscall", 32'h0000_000C, 32'h3, 32'h4);
    check("sys_flag", 32'(syscall), 32'd1);
    check("sys_rw", 32'(reg_write), 32'd0);

    // IR must hold when inst_load is low even though inst_in changes.
    for (int k = 0; k < 3; k++) begin
      @(negedge cpu_clk);
      inst_in = 32'h2022_1234 + 32'(k);
      sb.push_back(model(cur_ir, rs_data, rt_data));
      @(posedge cpu_clk);
      #1;
      compare_out("hold");
    end
    check("hold_inst", inst, 32'h0000_000C);

    load("j", 32'h0812_3456, 32'h9, 32'h9);
    check("j_target", 32'(decode_jmp_target), 32'h0012_3456);

    for (int n = 0; n < 40; n++) begin
      ir = $urandom;
      ir[31:26] = ops[$urandom_range(0, 10)];
      if (ir[31:26] == 6'd0) ir[5:0] = fns[$urandom_range(0, 8)];
      load("rand", ir, pick_val(), pick_val());
      check("rand_fields", {decode_opcode, decode_rs, decode_rt, decode_rd, decode_shamt, decode_funct}, ir);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
